// File: rtl/dff_edge_checker.sv
// rtl/dff_edge_checker.sv - response monitor for an edge-triggered D flip-flop
module dff_edge_checker #(
  parameter int SETTLE = 2,
  parameter int ERR_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             c_in,
  input  logic             d_in,
  input  logic             q_in,
  input  logic             qn_in,
  output logic             exp_q,
  output logic             exp_valid,
  output logic             err_pulse,
  output logic             overrun,
  output logic [ERR_W-1:0] err_count,
  output logic [ERR_W-1:0] chk_count,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, WAIT, CHECK} state_t;

  localparam logic [3:0] RELOAD = 4'(SETTLE - 1);

  state_t     state, state_nxt;
  logic       c_prev;
  logic [3:0] cnt, cnt_nxt;
  logic       exp_q_nxt, exp_valid_nxt;
  logic       err_nxt, ovr_nxt, inc_chk, inc_err;
  logic       rise, pass;

  assign rise = c_in & ~c_prev;
  // Q==Qn can never satisfy both terms, so that failure needs no special case
  assign pass = (q_in == exp_q) && (qn_in == ~exp_q);
  assign busy = (state != IDLE);

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    exp_q_nxt     = exp_q;
    exp_valid_nxt = exp_valid;
    err_nxt       = 1'b0;
    ovr_nxt       = 1'b0;
    inc_chk       = 1'b0;
    inc_err       = 1'b0;
    case (state)
      IDLE: begin
        if (en && rise) begin
          exp_q_nxt     = d_in;
          exp_valid_nxt = 1'b1;
          cnt_nxt       = RELOAD;
          state_nxt     = WAIT;
        end
      end
      WAIT: begin
        if (rise) begin
          ovr_nxt   = 1'b1;
          exp_q_nxt = d_in;
          cnt_nxt   = RELOAD;
        end else if (cnt == 4'd0) begin
          state_nxt = CHECK;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      CHECK: begin
        inc_chk = 1'b1;
        inc_err = ~pass;
        err_nxt = ~pass;
        // an edge landing on the compare cycle starts a fresh capture
        if (en && rise) begin
          exp_q_nxt = d_in;
          cnt_nxt   = RELOAD;
          state_nxt = WAIT;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      c_prev    <= 1'b0;
      cnt       <= 4'd0;
      exp_q     <= 1'b0;
      exp_valid <= 1'b0;
      err_pulse <= 1'b0;
      overrun   <= 1'b0;
      err_count <= '0;
      chk_count <= '0;
    end else begin
      state     <= state_nxt;
      c_prev    <= c_in;
      cnt       <= cnt_nxt;
      exp_q     <= exp_q_nxt;
      exp_valid <= exp_valid_nxt;
      err_pulse <= err_nxt;
      overrun   <= ovr_nxt;
      if (inc_chk && (chk_count != '1)) chk_count <= chk_count + ERR_W'(1);
      if (inc_err && (err_count != '1)) err_count <= err_count + ERR_W'(1);
    end
  end

endmodule

// File: tb/tb_dff_edge_checker.sv
// tb/tb_dff_edge_checker.sv - table-driven bench for dff_edge_checker
module tb_dff_edge_checker;

  logic clk = 1'b0;
  logic rst, en, c_in, d_in, q_in, qn_in;

  logic       exp_q, exp_valid, err_pulse, overrun, busy;
  logic [7:0] err_count, chk_count;
  logic       exp_q2, exp_valid2, err_pulse2, overrun2, busy2;
  logic [1:0] err_count2, chk_count2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dff_edge_checker #(.SETTLE(2), .ERR_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .c_in(c_in), .d_in(d_in), .q_in(q_in), .qn_in(qn_in),
    .exp_q(exp_q), .exp_valid(exp_valid), .err_pulse(err_pulse), .overrun(overrun),
    .err_count(err_count), .chk_count(chk_count), .busy(busy)
  );

  dff_edge_checker #(.SETTLE(2), .ERR_W(2)) dut2 (
    .clk(clk), .rst(rst), .en(en), .c_in(c_in), .d_in(d_in), .q_in(q_in), .qn_in(qn_in),
    .exp_q(exp_q2), .exp_valid(exp_valid2), .err_pulse(err_pulse2), .overrun(overrun2),
    .err_count(err_count2), .chk_count(chk_count2), .busy(busy2)
  );

  typedef struct {
    logic [5:0]  stim;  // rst en c d q qn
    logic [20:0] want;  // exp_q exp_valid err_pulse overrun busy err_count chk_count
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic [5:0] s, input logic [4:0] f, input int ec, input int cc);
    vec_t v;
    v.stim = s;
    v.want = {f, 8'(ec), 8'(cc)};
    tv.push_back(v);
  endtask

  task automatic cyc(input logic [5:0] s);
    {rst, en, c_in, d_in, q_in, qn_in} = s;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int want);
    n_cmp++;
    if (act != want) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, want);
    end
  endtask

  initial begin
    logic [20:0] got;
    int k;
    {rst, en, c_in, d_in, q_in, qn_in} = 6'b100000;

    //   rst en c d q qn     eq ev ep ov busy   err chk
    add(6'b100000, 5'b00000, 0, 0);  // reset
    add(6'b010100, 5'b00000, 0, 0);
    add(6'b011100, 5'b11001, 0, 0);  // rise, D=1
    add(6'b011000, 5'b11001, 0, 0);
    add(6'b010000, 5'b11001, 0, 0);  // enter CHECK
    add(6'b010010, 5'b11000, 0, 1);  // pass
    add(6'b011010, 5'b01001, 0, 1);  // rise, D=0
    add(6'b010110, 5'b01001, 0, 1);
    add(6'b010110, 5'b01001, 0, 1);
    add(6'b010110, 5'b01100, 1, 2);  // Q=1 vs exp 0: fail
    add(6'b010110, 5'b01000, 1, 2);  // pulse lasts one cycle
    add(6'b011110, 5'b11001, 1, 2);  // rise, D=1
    add(6'b011110, 5'b11001, 1, 2);
    add(6'b010110, 5'b11001, 1, 2);
    add(6'b010111, 5'b11100, 2, 3);  // Q=Qn=1: fail
    add(6'b010110, 5'b11000, 2, 3);
    add(6'b011110, 5'b11001, 2, 3);  // rise at t, D=1
    add(6'b010110, 5'b11001, 2, 3);
    add(6'b011010, 5'b01011, 2, 3);  // rise at t+2, D=0: overrun
    add(6'b011001, 5'b01001, 2, 3);
    add(6'b010001, 5'b01001, 2, 3);
    add(6'b010001, 5'b01000, 2, 4);  // single compare, pass vs 0
    add(6'b011101, 5'b11001, 2, 4);
    add(6'b010101, 5'b11001, 2, 4);
    add(6'b010101, 5'b11001, 2, 4);
    add(6'b011010, 5'b01001, 2, 5);  // CHECK with rise: pass, new capture D=0
    add(6'b011010, 5'b01001, 2, 5);
    add(6'b010010, 5'b01001, 2, 5);
    add(6'b010001, 5'b01000, 2, 6);
    add(6'b001101, 5'b01000, 2, 6);  // en=0, C toggles
    add(6'b000101, 5'b01000, 2, 6);
    add(6'b001101, 5'b01000, 2, 6);
    add(6'b000101, 5'b01000, 2, 6);
    add(6'b001101, 5'b01000, 2, 6);  // C high before enable
    add(6'b011101, 5'b01000, 2, 6);  // enable with C already high: no edge
    add(6'b010101, 5'b01000, 2, 6);
    add(6'b011110, 5'b11001, 2, 6);  // true rise
    add(6'b010110, 5'b11001, 2, 6);
    add(6'b000110, 5'b11001, 2, 6);  // en drops mid-WAIT, compare still runs
    add(6'b000110, 5'b11000, 2, 7);
    add(6'b011010, 5'b01001, 2, 7);  // capture
    add(6'b110010, 5'b00000, 0, 0);  // reset mid-WAIT
    add(6'b010010, 5'b00000, 0, 0);

    foreach (tv[i]) begin
      cyc(tv[i].stim);
      got = {exp_q, exp_valid, err_pulse, overrun, busy, err_count, chk_count};
      n_cmp++;
      if (got !== tv[i].want) begin
        n_bad++;
        $display("FAIL row%0d: got %b_%0d_%0d, expected %b_%0d_%0d", i,
                 got[20:16], got[15:8], got[7:0],
                 tv[i].want[20:16], tv[i].want[15:8], tv[i].want[7:0]);
      end
    end

    // five consecutive failures: 2-bit counters saturate at 3
    for (k = 1; k <= 5; k++) begin
      cyc(6'b011101);
      cyc(6'b010001);
      cyc(6'b010001);
      cyc(6'b010001);
      check($sformatf("sat_err%0d", k), int'(err_count2), (k > 3) ? 3 : k);
      check($sformatf("sat_chk%0d", k), int'(chk_count2), (k > 3) ? 3 : k);
      check($sformatf("wide_err%0d", k), int'(err_count), k);
      check($sformatf("sat_pulse%0d", k), int'(err_pulse2), 1);
    end

    // reset during CHECK with a failing Q: compare abandoned
    cyc(6'b011101);
    cyc(6'b010001);
    cyc(6'b010001);
    check("chk_state_busy", int'(busy), 1);
    cyc(6'b110001);
    check("rst_chk_pulse", int'(err_pulse), 0);
    check("rst_chk_err", int'(err_count2), 0);
    check("rst_chk_valid", int'(exp_valid), 0);
    check("rst_chk_busy", int'(busy), 0);
    cyc(6'b010001);
    check("rst_chk_pulse_after", int'(err_pulse), 0);
    check("rst_chk_cnt_after", int'(chk_count), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dff_edge_checker.md
Name: dff_edge_checker

Overview:
- Self-checking response monitor for the edge-triggered D flip-flop.
- Observes the DUT's clock, data and both outputs as synchronous samples on a fast system clock.
- Computes the expected Q at every rising edge of the DUT clock and flags and counts any mismatch after a settle window.
- Sits beside the DUT in benches and on-board test harnesses, on the receiving side of the stimulus driver.

Parameters:
- SETTLE, 2, system-clock cycles between a detected DUT clock edge and the compare; legal range 1..15.
- ERR_W, 8, width of the error and check counters.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  checking enable; when low, the block holds in IDLE and ignores edges.
- c_in  input  1  sampled DUT clock C, synchronous to clk.
- d_in  input  1  sampled DUT data D.
- q_in  input  1  sampled DUT output Q.
- qn_in  input  1  sampled DUT output Qn.
- exp_q  output  1  expected Q, as captured at the last DUT clock edge.
- exp_valid  output  1  high once at least one edge has been captured since reset.
- err_pulse  output  1  one-cycle pulse on a failed compare.
- overrun  output  1  one-cycle pulse when an edge arrives before the pending compare.
- err_count  output  ERR_W  saturating count of failed compares.
- chk_count  output  ERR_W  saturating count of completed compares.
- busy  output  1  high in WAIT or CHECK.

Behaviour:
- Reset, applied when rst=1 at a clk edge:
  - State goes to IDLE.
  - c_prev=0, exp_q=0, exp_valid=0, err_pulse=0, overrun=0, err_count=0, chk_count=0, busy=0.
  - Settle counter goes to 0.
- Edge detect: rise = c_in & ~c_prev. c_prev registers c_in every cycle, including in IDLE and while en=0, so enabling never produces a false edge.
- IDLE:
  - If en & rise: exp_q <= d_in, exp_valid <= 1, counter <= SETTLE-1, go to WAIT.
  - Otherwise stay in IDLE.
- WAIT:
  - If rise: this is an overrun.
    - overrun pulses.
    - exp_q <= d_in.
    - Counter reloads to SETTLE-1.
    - Stay in WAIT; the previous compare is abandoned.
  - Else if counter==0: go to CHECK.
  - Else decrement the counter.
- CHECK (one cycle):
  - Pass condition: q_in==exp_q and qn_in==~exp_q.
  - On fail: err_pulse=1 in the following cycle.
  - chk_count increments on every CHECK; err_count increments on fail. Both saturate at all-ones.
  - Next state: WAIT if en & rise in this cycle (treated as a new capture, not an overrun), else IDLE.
- Latency: with rise seen at cycle t, CHECK occurs at t+SETTLE+1 and err_pulse is high at t+SETTLE+2.
- en deassert:
  - Takes effect only in IDLE; a pending WAIT or CHECK still completes.
  - A rise while en=0 in IDLE is ignored, and exp_q is unchanged.
- Qn check: both-equal outputs (Q==Qn) fail regardless of exp_q.
- Reset mid-WAIT or mid-CHECK: the compare is abandoned, there is no err_pulse, and all outputs return to their reset values the next cycle.
- Counters never wrap. Once at 2^ERR_W-1 they hold until reset.

Test Plan:
- Reset then en=1, SETTLE=2. D=1, C rises at cycle 5, DUT Q=1, Qn=0 → exp_q=1, CHECK at cycle 8, chk_count=1, err_count=0, no err_pulse.
- D=0, C rises, DUT holds Q=1, Qn=0 → err_pulse high for exactly one cycle at t+4, err_count=1, chk_count=2.
- Q=1, Qn=1 with exp_q=1 → fail, err_count increments.
- C rises at t, again at t+2 with D changed 1→0 → overrun pulse at t+3, exp_q=0, only one compare completes, at t+5.
- en=0 while C toggles 4 times → state stays IDLE, counts unchanged. Then raise en with C already high → no capture until the next true rise.
- ERR_W=2: force 5 consecutive failures → err_count stops at 3. Assert rst during a WAIT → no err_pulse, counts and exp_valid cleared.
